uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/uart_tx_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice.
//   - uart_state_e : transmitter FSM states (PARITY state exists only when
//                    UART_TX_PARITY_EN is defined)
//   - PAR_*        : parity mode encodings used by the PARITY parameter
//   - baud_div()   : clocks per serial bit, truncating division
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head entry is always visible on rd_data; pop consumes it.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointers/flags only)
//   push, wr_data   : write request and data (ignored when full)
//   pop, rd_data    : read request (ignored when empty) and head data
//   full, empty     : registered status flags
//   level           : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    // Gating uses the registered flags, so a pop at full never admits a push
    // in the same cycle.
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == FULL_LVL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input byte FIFO.
// Bytes are accepted on tx_valid & tx_ready, queued in sync_fifo and sent
// as start bit, DATA_BITS data bits LSB first, optional parity, and
// STOP_BITS stop bits, each held for CLK_FREQ/BAUD clocks.
// Build option: define UART_TX_PARITY_EN to include the parity generator and
// PARITY state; without it PARITY is ignored and no parity bit is sent.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tx_data    : byte to send (bits above DATA_BITS-1 ignored)
//   tx_valid   : producer offers tx_data
//   tx_ready   : FIFO not full (registered flag)
//   uart_txd   : serial output, idle high
//   tx_busy    : high while a frame is on the line
//   fifo_level : number of queued bytes
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam int PAR_MODE = PARITY;
`else
  // Parity hardware is not built, so the requested mode is forced to none.
  localparam int PAR_MODE = PAR_NONE + 0 * PARITY;
`endif

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_rd;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_valid),
    .wr_data (tx_data[DATA_BITS-1:0]),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tx_ready = !fifo_full;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 bit_done, start_frame;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    // Odd: data plus parity has odd weight; even: even weight.
    return (PAR_MODE == PAR_ODD) ? ~(^d) : (^d);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    start_frame = 1'b0;
    bit_done    = (baud_cnt_q == BIT_LAST);
    if (state_q != ST_IDLE) baud_cnt_d = bit_done ? '0 : baud_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (!fifo_empty) start_frame = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      state_d    = ST_START;
      shift_d    = fifo_rd;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end
    fifo_pop = start_frame;
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (start_frame) par_d = parity_bit(fifo_rd);
  end
`endif

  // Line and busy outputs are registered from the current state, so they
  // trail the state register by one clock; every bit still lasts BAUD_DIV.
  always_comb begin
    busy_d = (state_q != ST_IDLE);
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four instances with different configurations,
// a line monitor decoding the selected instance against an expected-bit queue.
module tb_uart_tx_fifo;

  localparam int DIV = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       txd      [4];
  logic       busy     [4];
  logic [4:0] lvl0, lvl1, lvl3;
  logic [2:0] lvl2;

  uart_tx_fifo u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .uart_txd(txd[0]), .tx_busy(busy[0]), .fifo_level(lvl0));

  uart_tx_fifo #(.STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .uart_txd(txd[1]), .tx_busy(busy[1]), .fifo_level(lvl1));

  uart_tx_fifo #(.FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .uart_txd(txd[2]), .tx_busy(busy[2]), .fifo_level(lvl2));

  uart_tx_fifo #(.PARITY(2), .DATA_BITS(7)) u3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .uart_txd(txd[3]), .tx_busy(busy[3]), .fifo_level(lvl3));

`ifdef UART_TX_PARITY_EN
  localparam int U3_PAR = 2;
`else
  localparam int U3_PAR = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard
  int  exp_len_q[$];
  bit  exp_bit_q[$];
  int  frame_t0[$];
  int  frames_seen = 0;
  int  cyc = 0;
  int  sel = 0;
  bit  mon_en = 1'b0;
  bit  mon_active = 1'b0;
  int  busy_cnt0 = 0;
  logic mon_txd;

  assign mon_txd = txd[sel];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy[0] === 1'b1) busy_cnt0 <= busy_cnt0 + 1;

  function automatic void expect_frame(input logic [7:0] d, input int dbits,
                                       input int par, input int stops);
    int n;
    bit p;
    n = 0;
    p = 1'b0;
    exp_bit_q.push_back(1'b0); n++;
    for (int i = 0; i < dbits; i++) begin
      exp_bit_q.push_back(d[i]);
      p ^= d[i];
      n++;
    end
    if (par == 1) begin exp_bit_q.push_back(~p); n++; end
    else if (par == 2) begin exp_bit_q.push_back(p); n++; end
    for (int i = 0; i < stops; i++) begin exp_bit_q.push_back(1'b1); n++; end
    exp_len_q.push_back(n);
  endfunction

  // Line monitor: a frame starts at the first low sample; each bit is checked
  // on its first and last clock.
  initial begin
    int len;
    bit eb;
    int guard;
    forever begin
      @(negedge clk);
      if (mon_en && mon_txd === 1'b0) begin
        mon_active = 1'b1;
        frames_seen++;
        frame_t0.push_back(cyc);
        if (exp_len_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          guard = 0;
          while (mon_txd !== 1'b1 && guard < 20 * DIV) begin @(negedge clk); guard++; end
        end else begin
          len = exp_len_q.pop_front();
          for (int k = 0; k < len; k++) begin
            eb = exp_bit_q.pop_front();
            if (k > 0) @(negedge clk);
            check($sformatf("f%0d_bit%0d_first", frames_seen, k), mon_txd, eb);
            repeat (DIV - 1) @(negedge clk);
            check($sformatf("f%0d_bit%0d_last", frames_seen, k), mon_txd, eb);
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic push(input int s, input logic [7:0] d);
    @(negedge clk);
    tx_data[s]  = d;
    tx_valid[s] = 1'b1;
    @(posedge clk);
    #1 tx_valid[s] = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while ((exp_len_q.size() > 0 || mon_active) && n < max) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_in_time"}, (n < max), 1'b1);
  endtask

  initial begin
    int acc;
    int f0;
    int lows;
    int guard;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin tx_valid[i] = 1'b0; tx_data[i] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_ready", tx_ready[0], 1'b1);
    check("rst_level", lvl0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Default config, single 0x55 frame.
    sel = 0; mon_en = 1'b1; frame_t0.delete(); busy_cnt0 = 0;
    expect_frame(8'h55, 8, 0, 1);
    push(0, 8'h55);
    acc = cyc;
    check("level_after_push", lvl0, 1);
    wait_drain("a", 6000);
    repeat (5) @(negedge clk);
    check("start_latency", (frame_t0.size() > 0) ? frame_t0[0] - acc : -1, 2);
    check("busy_cycles", busy_cnt0, 10 * DIV);
    check("idle_line", txd[0], 1'b1);

    // Two stop bits, back-to-back frames.
    sel = 1; frame_t0.delete();
    expect_frame(8'hA5, 8, 0, 2);
    expect_frame(8'h3C, 8, 0, 2);
    push(1, 8'hA5);
    push(1, 8'h3C);
    wait_drain("b", 12000);
    check("b2b_spacing", (frame_t0.size() > 1) ? frame_t0[1] - frame_t0[0] : -1, 11 * DIV);

    // Depth-4 FIFO overflow while the line is busy.
    sel = 2; frame_t0.delete(); f0 = frames_seen;
    expect_frame(8'h10, 8, 0, 1);
    push(2, 8'h10);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("ovf_ready%0d", i), tx_ready[2], (i < 4));
      tx_data[2]  = 8'h20 + 8'(i);
      tx_valid[2] = 1'b1;
      if (i < 4) expect_frame(8'h20 + 8'(i), 8, 0, 1);
      @(posedge clk);
      #1 tx_valid[2] = 1'b0;
    end
    @(negedge clk);
    check("ovf_level", lvl2, 4);
    check("ovf_ready_full", tx_ready[2], 1'b0);
    wait_drain("c", 6 * 10 * DIV);
    repeat (2 * DIV) @(negedge clk);
    check("ovf_frames", frames_seen - f0, 5);

    // Parity instance, 7 data bits.
    sel = 3; frame_t0.delete();
    expect_frame(8'h83, 7, U3_PAR, 1);
    push(3, 8'h83);
    wait_drain("d", 6000);

    // Reset mid-frame.
    sel = 0; mon_en = 1'b0;
    push(0, 8'h41);
    push(0, 8'h42);
    guard = 0;
    while (txd[0] !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    check("rst_frame_started", txd[0], 1'b0);
    repeat (1000) @(negedge clk);
    check("rst_pre_level", lvl0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_txd", txd[0], 1'b1);
    check("rst_mid_busy", busy[0], 1'b0);
    check("rst_mid_level", lvl0, 0);
    check("rst_mid_ready", tx_ready[0], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (6000) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    check("rst_no_frames", lows, 0);
    check("scoreboard_empty", exp_len_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
